// File: rtl/vec_mem_sequencer_if.sv
// Core/RAM bundle seen by the vector memory sequencer.
// The sequencer takes the slave view; the core plus RAM environment takes the master view.
// Every signal is combinational except where the sequencer registers it internally.
interface vec_mem_sequencer_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 32
);
  // Core memory-stage requests
  logic             MemWriteM;
  logic [WIDTH-1:0] ALUOutM;
  logic [WIDTH-1:0] WriteDataM;
  logic             MemWriteVecM;
  logic             MemReadVecM;
  logic [WIDTH-1:0] VectorAddressM [0:LANES-1];
  logic [WIDTH-1:0] WriteDataMVec  [0:LANES-1];
  // Results returned to the core
  logic [WIDTH-1:0] ReadDataM;
  logic [WIDTH-1:0] ReadDataVecM   [0:LANES-1];
  logic             StallM;
  logic             AlignErr;
  // Single-port RAM side
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output MemWriteM, ALUOutM, WriteDataM, MemWriteVecM, MemReadVecM,
    output VectorAddressM, WriteDataMVec, mem_rdata,
    input  ReadDataM, ReadDataVecM, StallM, AlignErr,
    input  mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  MemWriteM, ALUOutM, WriteDataM, MemWriteVecM, MemReadVecM,
    input  VectorAddressM, WriteDataMVec, mem_rdata,
    output ReadDataM, ReadDataVecM, StallM, AlignErr,
    output mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Serializes LANES-wide vector loads/stores onto a word-wide single-port RAM; scalars pass through.
// Latency: scalar 0 cycles; vector op LANES cycles, last load lane bypassed to ReadDataVecM.
// Backpressure: StallM holds the core for LANES-1 cycles; a new op may start the cycle after completion.
module vec_mem_sequencer #(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  vec_mem_sequencer_if.slave  bus
);

  localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LCW-1:0] LAST_LANE = LCW'(LANES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [LCW-1:0]   lc;
  logic             is_store;
  logic             align_err;
  logic [WIDTH-1:0] addr_q   [0:LANES-1];
  logic [WIDTH-1:0] wdata_q  [0:LANES-1];
  logic [WIDTH-1:0] lane_buf [0:LANES-1];
  logic [WIDTH-1:0] rdvec_q  [0:LANES-1];

  logic vec_req;
  logic last_load_lane;
  logic misaligned;
  logic we_c;
  logic stall_c;

  assign vec_req        = bus.MemWriteVecM | bus.MemReadVecM;
  assign last_load_lane = (state == BUSY) && (lc == LAST_LANE) && !is_store;

  // Flag any live lane address that is not word aligned; only looked at on capture.
  always_comb begin
    misaligned = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.VectorAddressM[i][1:0] != 2'b00) misaligned = 1'b1;
    end
  end

  // RAM port steering: captured lane while busy, live lane 0 on start, scalar otherwise.
  always_comb begin
    bus.mem_addr  = bus.ALUOutM;
    bus.mem_wdata = bus.WriteDataM;
    we_c          = bus.MemWriteM;
    stall_c       = 1'b0;
    if (state == BUSY) begin
      bus.mem_addr  = addr_q[lc];
      bus.mem_wdata = wdata_q[lc];
      we_c          = is_store;
      stall_c       = (lc != LAST_LANE);
    end else if (vec_req) begin
      bus.mem_addr  = bus.VectorAddressM[0];
      bus.mem_wdata = bus.WriteDataMVec[0];
      we_c          = bus.MemWriteVecM;
      stall_c       = 1'b1;
    end
    // Reset must silence the RAM and release the core at once, whatever the inputs say.
    bus.mem_we = we_c & reset;
    bus.StallM = stall_c & reset;
  end

  assign bus.ReadDataM = bus.mem_rdata;
  assign bus.AlignErr  = align_err;

  // Vector load result: in the final lane the last word bypasses straight from the RAM.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (last_load_lane) begin
        bus.ReadDataVecM[i] = (i == LANES - 1) ? bus.mem_rdata : lane_buf[i];
      end else begin
        bus.ReadDataVecM[i] = rdvec_q[i];
      end
    end
  end

  // Sequencer FSM: capture the op on start, walk lanes, publish load data on the last lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lc        <= '0;
      is_store  <= 1'b0;
      align_err <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        addr_q[i]   <= '0;
        wdata_q[i]  <= '0;
        lane_buf[i] <= '0;
        rdvec_q[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (vec_req) begin
            state    <= BUSY;
            lc       <= LCW'(1);
            // A simultaneous load+store request is handled as a store.
            is_store <= bus.MemWriteVecM;
            for (int i = 0; i < LANES; i++) begin
              addr_q[i]  <= bus.VectorAddressM[i];
              wdata_q[i] <= bus.WriteDataMVec[i];
            end
            if (!bus.MemWriteVecM) lane_buf[0] <= bus.mem_rdata;
            if (misaligned) align_err <= 1'b1;
          end
        end
        BUSY: begin
          if (!is_store) lane_buf[lc] <= bus.mem_rdata;
          if (lc == LAST_LANE) begin
            state <= IDLE;
            lc    <= '0;
            if (!is_store) begin
              for (int i = 0; i < LANES; i++) begin
                rdvec_q[i] <= (i == LANES - 1) ? bus.mem_rdata : lane_buf[i];
              end
            end
          end else begin
            lc <= lc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          lc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: behavioural RAM plus a word-array reference model of memory contents,
// held vector results and the sticky alignment flag; directed plan steps followed by random vector ops.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_vec_mem_sequencer;

  localparam int LANES = 4;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vec_mem_sequencer_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  vec_mem_sequencer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Word-wide RAM: combinational read, write on rising edge, low address bits ignored.
  logic [31:0] ram [0:255];
  assign bus.mem_rdata = ram[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  // Reference model state
  logic [31:0] exp_mem [0:255];
  logic [31:0] exp_rdvec [0:LANES-1];
  logic        exp_align;
  logic [31:0] op_addr [0:LANES-1];
  logic [31:0] op_data [0:LANES-1];
  logic [31:0] nxt_addr [0:LANES-1];
  logic [31:0] nxt_data [0:LANES-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_hold(input string tag);
    for (int i = 0; i < LANES; i++)
      chk($sformatf("%s_vec%0d", tag, i), bus.ReadDataVecM[i], exp_rdvec[i]);
    chk1({tag, "_align"}, bus.AlignErr, exp_align);
  endtask

  function automatic logic [31:0] raddr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 15));
    return {22'b0, w, 2'b00};
  endfunction

  task automatic idle_inputs();
    bus.MemWriteM    = 1'b0;
    bus.ALUOutM      = '0;
    bus.WriteDataM   = '0;
    bus.MemWriteVecM = 1'b0;
    bus.MemReadVecM  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      bus.VectorAddressM[i] = '0;
      bus.WriteDataMVec[i]  = '0;
    end
  endtask

  task automatic scramble();
    bus.MemWriteM    = 1'($urandom_range(0, 1));
    bus.ALUOutM      = $urandom;
    bus.WriteDataM   = $urandom;
    bus.MemWriteVecM = 1'($urandom_range(0, 1));
    bus.MemReadVecM  = 1'($urandom_range(0, 1));
    for (int i = 0; i < LANES; i++) begin
      bus.VectorAddressM[i] = $urandom;
      bus.WriteDataMVec[i]  = $urandom;
    end
  endtask

  task automatic drive_op(input bit st, input bit ld, input bit sw);
    bus.MemWriteVecM = st;
    bus.MemReadVecM  = ld;
    bus.MemWriteM    = sw;
    bus.ALUOutM      = 32'h40;
    bus.WriteDataM   = $urandom;
    for (int i = 0; i < LANES; i++) begin
      bus.VectorAddressM[i] = op_addr[i];
      bus.WriteDataMVec[i]  = op_data[i];
    end
  endtask

  task automatic scalar(input bit we, input logic [31:0] addr, input logic [31:0] data);
    bus.MemWriteVecM = 1'b0;
    bus.MemReadVecM  = 1'b0;
    bus.MemWriteM    = we;
    bus.ALUOutM      = addr;
    bus.WriteDataM   = data;
    @(negedge clk);
    chk1("sc_stall", bus.StallM, 1'b0);
    chk("sc_addr", bus.mem_addr, addr);
    chk1("sc_we", bus.mem_we, we);
    if (we) chk("sc_wdata", bus.mem_wdata, data);
    chk("sc_rdata", bus.ReadDataM, exp_mem[addr[9:2]]);
    chk_hold("sc");
    @(posedge clk); #1;
    if (we) exp_mem[addr[9:2]] = data;
    idle_inputs();
  endtask

  // One vector op of LANES cycles. pre: request already driven by a chained predecessor.
  // chain: drive the nxt_* op (nst/nld) right in the cycle after completion.
  task automatic vec_op(input bit st, input bit ld, input bit sw, input bit pre,
                        input bit chain, input bit nst, input bit nld);
    bit store;
    bit mis;
    logic [31:0] res [0:LANES-1];
    store = st;
    mis   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      res[i] = exp_mem[op_addr[i][9:2]];
      if (op_addr[i][1:0] != 2'b00) mis = 1'b1;
    end
    if (!pre) drive_op(st, ld, sw);
    for (int k = 0; k < LANES; k++) begin
      @(negedge clk);
      chk1($sformatf("v_stall%0d", k), bus.StallM, k < LANES - 1);
      chk($sformatf("v_addr%0d", k), bus.mem_addr, op_addr[k]);
      chk1($sformatf("v_we%0d", k), bus.mem_we, store);
      if (store) chk($sformatf("v_wdata%0d", k), bus.mem_wdata, op_data[k]);
      chk($sformatf("v_rdata%0d", k), bus.ReadDataM, exp_mem[op_addr[k][9:2]]);
      if (k == LANES - 1 && !store) begin
        for (int i = 0; i < LANES; i++)
          chk($sformatf("v_ld_vec%0d", i), bus.ReadDataVecM[i], res[i]);
        chk1("v_ld_align", bus.AlignErr, exp_align);
      end else begin
        chk_hold($sformatf("v_hold%0d", k));
      end
      @(posedge clk); #1;
      if (store) exp_mem[op_addr[k][9:2]] = op_data[k];
      if (k == 0) exp_align = exp_align | mis;
      if (k < LANES - 1) begin
        scramble();
      end else if (chain) begin
        op_addr = nxt_addr;
        op_data = nxt_data;
        drive_op(nst, nld, 1'b0);
      end else begin
        idle_inputs();
      end
    end
    if (!store) exp_rdvec = res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] base;
    logic [31:0] lane3;
    bit          st, ld;

    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      exp_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < LANES; i++) exp_rdvec[i] = '0;
    exp_align = 1'b0;

    // Reset with a vector store and scalar store requested: nothing may reach the RAM.
    reset = 1'b0;
    idle_inputs();
    bus.MemWriteVecM = 1'b1;
    bus.MemWriteM    = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_stall", bus.StallM, 1'b0);
    chk1("rst_we", bus.mem_we, 1'b0);
    chk_hold("rst");
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;

    // Scalar write then same-cycle read back
    scalar(1'b1, 32'h40, 32'hDEAD_BEEF);
    scalar(1'b0, 32'h40, 32'h0);
    chk("sc_deadbeef", exp_mem[32'h40 >> 2], 32'hDEAD_BEEF);

    // Directed vector store then vector load of the same words
    for (int i = 0; i < LANES; i++) begin
      op_addr[i] = 32'h100 + 32'(4 * i);
      op_data[i] = 32'(i + 1);
    end
    vec_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LANES; i++) chk($sformatf("ram_st%0d", i), ram[(32'h100 >> 2) + i], 32'(i + 1));
    vec_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LANES; i++) chk($sformatf("ld_const%0d", i), exp_rdvec[i], 32'(i + 1));
    scalar(1'b0, 32'h200, 32'h0);

    // Back-to-back store then load with no idle cycle
    for (int i = 0; i < LANES; i++) begin
      op_addr[i]  = raddr();
      op_data[i]  = $urandom;
      nxt_addr[i] = raddr();
      nxt_data[i] = $urandom;
    end
    vec_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vec_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random vector ops, sometimes separated by scalar traffic
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < LANES; i++) begin
        op_addr[i] = raddr();
        op_data[i] = $urandom;
      end
      st = 1'($urandom_range(0, 1));
      ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
      vec_op(st, ld, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1)
        scalar(1'($urandom_range(0, 1)), raddr(), $urandom);
    end

    // Misaligned lane 1 with a competing scalar store: vector load wins, AlignErr sticks
    for (int i = 0; i < LANES; i++) begin
      op_addr[i] = 32'h100 + 32'(4 * i);
      op_data[i] = $urandom;
    end
    op_addr[1] = 32'h105;
    vec_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("align_set", exp_align, 1'b1);
    scalar(1'b0, 32'h40, 32'h0);
    // Both vector requests high act as a store
    for (int i = 0; i < LANES; i++) begin
      op_addr[i] = raddr();
      op_data[i] = $urandom;
    end
    vec_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    scalar(1'b0, op_addr[0], 32'h0);

    // Reset during lane 2 of a vector store
    base = {22'b0, 8'($urandom_range(0, 40)), 2'b00};
    for (int i = 0; i < LANES; i++) begin
      op_addr[i] = base + 32'(4 * i);
      op_data[i] = $urandom;
    end
    lane3 = op_addr[3];
    drive_op(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("mid_addr%0d", k), bus.mem_addr, op_addr[k]);
      @(posedge clk); #1;
      exp_mem[op_addr[k][9:2]] = op_data[k];
      scramble();
    end
    idle_inputs();
    bus.ALUOutM = 32'h3F0;
    reset = 1'b0;
    #1;
    chk1("mid_stall", bus.StallM, 1'b0);
    chk1("mid_we", bus.mem_we, 1'b0);
    for (int i = 0; i < LANES; i++) exp_rdvec[i] = '0;
    exp_align = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("mid_no_lane3", bus.mem_addr != lane3, 1'b1);
      chk1("mid_we_low", bus.mem_we, 1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    for (int i = 0; i < LANES; i++) scalar(1'b0, op_addr[i], 32'h0);
    vec_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    scalar(1'b0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Sits directly downstream of the pipelined core's memory stage, between the core and a single-port, word-wide data RAM.
- Passes scalar loads and stores straight through.
- Serializes each 4-lane vector load or store into LANES consecutive RAM accesses, one lane per cycle.
- Holds the core's pipeline with StallM until the last lane completes, then presents all gathered load data at once.

Parameters:
- LANES, 4, number of vector lanes serialized per vector op (power of two, 2..8).
- WIDTH, 32, data and address width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWriteM  input  1  scalar store request.
- ALUOutM  input  WIDTH  scalar address.
- WriteDataM  input  WIDTH  scalar store data.
- MemWriteVecM  input  1  vector store request.
- MemReadVecM  input  1  vector load request.
- VectorAddressM[0:LANES-1]  input  WIDTH each  per-lane addresses.
- WriteDataMVec[0:LANES-1]  input  WIDTH each  per-lane store data.
- ReadDataM  output  WIDTH  scalar load data.
- ReadDataVecM[0:LANES-1]  output  WIDTH each  per-lane load data.
- StallM  output  1  holds core fetch through memory stages while high.
- AlignErr  output  1  sticky misaligned-vector-lane flag.
- mem_addr  output  WIDTH  RAM address.
- mem_wdata  output  WIDTH  RAM write data.
- mem_we  output  1  RAM write enable, sampled at the rising edge.
- mem_rdata  input  WIDTH  RAM read data, combinational from mem_addr.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE and the lane counter to 0.
  - Lane buffers, ReadDataVecM and AlignErr clear to 0.
  - StallM=0 and mem_we=0 immediately.
  - A vector op in flight is abandoned; no further lane writes are issued.
- States: IDLE and BUSY, with lane counter lc (log2(LANES) bits).
- IDLE, no vector request:
  - mem_addr=ALUOutM, mem_wdata=WriteDataM, mem_we=MemWriteM.
  - ReadDataM=mem_rdata.
  - StallM=0. Zero-cycle scalar path.
- IDLE, MemWriteVecM or MemReadVecM high:
  - Start the op and access lane 0 from the live inputs: mem_addr=VectorAddressM[0], mem_we=MemWriteVecM, mem_wdata=WriteDataMVec[0].
  - StallM=1 combinationally.
  - On the clock edge, capture all addresses, all write data and op type. On a load, capture mem_rdata into buffer lane 0.
  - Go to BUSY with lc=1.
- BUSY:
  - Access lane lc from the captured registers. On a load, buffer lane lc gets mem_rdata.
  - While lc<LANES-1, StallM=1 and lc increments.
  - At lc=LANES-1, StallM=0 and the next state is IDLE.
- Load result timing:
  - In the final cycle, ReadDataVecM[0..LANES-2] come from the buffer and ReadDataVecM[LANES-1] bypasses mem_rdata.
  - From the next cycle, ReadDataVecM holds the registered buffer until the next vector load completes.
- Latency and back-to-back ops:
  - A vector op takes exactly LANES cycles with LANES-1 stall cycles.
  - A new request seen in the cycle after completion starts immediately, with no bubble.
- Priority:
  - If a vector request and MemWriteM are both high, the vector request wins and mem_we never reflects MemWriteM in that op.
  - If MemWriteVecM and MemReadVecM are both high, treat the op as a store.
- Vector store: ReadDataVecM is unchanged; ReadDataM=mem_rdata throughout.
- Alignment:
  - Any lane address with bits[1:0]≠0 at capture sets AlignErr, which stays set until reset.
  - The access is still issued with the address unmodified.
- Input changes while in BUSY are ignored, because the captured copy is used.
- mem_we is never high in two lanes of a load, and never high during BUSY of a load.

Test Plan:
- Scalar path:
  - Stimulus: IDLE, MemWriteM=1, ALUOutM=0x40, WriteDataM=0xDEADBEEF, then a scalar read of 0x40.
  - Required: the write lands with StallM=0 throughout, and ReadDataM=0xDEADBEEF in the same cycle as the read.
- Vector store:
  - Stimulus: addresses 0x100/0x104/0x108/0x10C, data 1/2/3/4.
  - Required: StallM=1,1,1,0 over 4 cycles; mem_addr sequence 0x100..0x10C; mem_we high all 4 cycles; RAM holds 1..4.
- Vector load:
  - Stimulus: the same addresses after the vector store.
  - Required: ReadDataVecM={1,2,3,4} in cycle 4 (lane 3 bypassed) and held afterward; mem_we=0 throughout.
- Back-to-back ops:
  - Stimulus: a vector store immediately followed by a vector load.
  - Required: 8 total cycles, StallM pattern 1,1,1,0,1,1,1,0, with no idle cycle between ops.
- Reset mid-op:
  - Stimulus: assert reset during lane 2 of a vector store.
  - Required: StallM=0 and mem_we=0 immediately; the lane 3 address is never driven; the state after release is IDLE with ReadDataVecM=0.
- Misalignment and priority:
  - Stimulus: a lane 1 address of 0x105 together with MemWriteM=1.
  - Required: AlignErr=1 after capture and sticky; no scalar write occurs; the op completes in 4 cycles.
